// File: rtl/hazard_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_pkg : Tuse/Tnew timing codes and bypass-select encodings  |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
package hazard_pkg;

    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;
    localparam logic [1:0] TUSE_NONE   = 2'd3;

    localparam logic [1:0] TNEW_READY  = 2'd0;
    localparam logic [1:0] TNEW_ALU    = 2'd1;
    localparam logic [1:0] TNEW_LOAD   = 2'd2;

    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_E       = 2'd1;
    localparam logic [1:0] FWD_M       = 2'd2;
    localparam logic [1:0] FWD_W       = 2'd3;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_pick(input logic e_ok, input logic m_ok,
                                            input logic w_ok);
        if (e_ok)      return FWD_E;
        else if (m_ok) return FWD_M;
        else if (w_ok) return FWD_W;
        else           return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_tracker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | md_busy_tracker : busy countdown for the multi-cycle mult/div    |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module md_busy_tracker #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_E,
    input  logic md_div_E,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] busy_cnt_d;

    // A start while still counting is ignored; the stall logic prevents it.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end else if (md_start_E) begin
            busy_cnt_d = md_div_E ? DIV_LOAD : MULT_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign md_busy = (busy_cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hazard_ctrl : stall/flush/bypass scheduler for the 5-stage MIPS  |
// |               pipeline. HAZARD_STATS_EN adds a stall counter.    |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  rt_M,
    input  logic [4:0]  a3_E,
    input  logic [4:0]  a3_M,
    input  logic [4:0]  a3_W,
    input  logic [1:0]  tnew_E,
    input  logic [1:0]  tnew_M,
    input  logic        md_D,
    input  logic        md_start_E,
    input  logic        md_div_E,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic        fwd_rt_M,
    output logic        md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    logic data_stall;
    logic md_stall;
    logic stall;

    md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_tracker (
        .clk        (clk),
        .reset      (reset),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .md_busy    (md_busy)
    );

    // A consumer stalls when it needs the value sooner than the producer makes it.
    always_comb begin
        data_stall = (reg_hit(rs_D, a3_E) && (tuse_rs_D < tnew_E))
                   | (reg_hit(rs_D, a3_M) && (tuse_rs_D < tnew_M))
                   | (reg_hit(rt_D, a3_E) && (tuse_rt_D < tnew_E))
                   | (reg_hit(rt_D, a3_M) && (tuse_rt_D < tnew_M));
        md_stall   = md_D && (md_busy || md_start_E);
        stall      = !reset && (data_stall || md_stall);
    end

    always_comb begin
        stall_F  = stall;
        stall_D  = stall;
        flush_E  = stall;
        fwd_rs_D = FWD_RF;
        fwd_rt_D = FWD_RF;
        fwd_rs_E = FWD_RF;
        fwd_rt_E = FWD_RF;
        fwd_rt_M = 1'b0;
        if (!reset) begin
            fwd_rs_D = fwd_pick(reg_hit(rs_D, a3_E) && (tnew_E == TNEW_READY),
                                reg_hit(rs_D, a3_M) && (tnew_M == TNEW_READY),
                                reg_hit(rs_D, a3_W));
            fwd_rt_D = fwd_pick(reg_hit(rt_D, a3_E) && (tnew_E == TNEW_READY),
                                reg_hit(rt_D, a3_M) && (tnew_M == TNEW_READY),
                                reg_hit(rt_D, a3_W));
            // The E stage cannot bypass from itself.
            fwd_rs_E = fwd_pick(1'b0,
                                reg_hit(rs_E, a3_M) && (tnew_M == TNEW_READY),
                                reg_hit(rs_E, a3_W));
            fwd_rt_E = fwd_pick(1'b0,
                                reg_hit(rt_E, a3_M) && (tnew_M == TNEW_READY),
                                reg_hit(rt_E, a3_W));
            fwd_rt_M = reg_hit(rt_M, a3_W);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(stall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hazard_ctrl : directed bench with a Tuse/Tnew reference model |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module tb_hazard_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D, rs_E, rt_E, rt_M, a3_E, a3_M, a3_W;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_D, md_start_E, md_div_E;
    logic        stall_F, stall_D, flush_E, fwd_rt_M, md_busy;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    hazard_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .rt_M       (rt_M),
        .a3_E       (a3_E),
        .a3_M       (a3_M),
        .a3_W       (a3_W),
        .tnew_E     (tnew_E),
        .tnew_M     (tnew_M),
        .md_D       (md_D),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .stall_F    (stall_F),
        .stall_D    (stall_D),
        .flush_E    (flush_E),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E),
        .fwd_rt_M   (fwd_rt_M),
        .md_busy    (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc      = 0;
    int          busy_end = 0;   // MD unit busy in every cycle c with c < busy_end
    bit          m_busy   = 1'b0;
    bit          chk_en   = 1'b0;
    logic [31:0] m_cnt    = '0;

    // Consumer needs src in tuse cycles; a producer at E/M delivers in tnew cycles.
    function automatic bit src_waits(input logic [4:0] src, input logic [1:0] tuse);
        logic [4:0] dst [2];
        int         tn  [2];
        dst[0] = a3_E; tn[0] = int'(tnew_E);
        dst[1] = a3_M; tn[1] = int'(tnew_M);
        if (src == 5'd0) return 1'b0;
        for (int s = 0; s < 2; s++)
            if (src == dst[s] && int'(tuse) < tn[s]) return 1'b1;
        return 1'b0;
    endfunction

    // Nearest stage (E=0, M=1, W=2) holding a finished value; select code = stage+1.
    function automatic int exp_fwd(input logic [4:0] src, input int first_stage);
        logic [4:0] dst [3];
        int         tn  [3];
        dst[0] = a3_E; tn[0] = int'(tnew_E);
        dst[1] = a3_M; tn[1] = int'(tnew_M);
        dst[2] = a3_W; tn[2] = 0;
        if (reset || src == 5'd0) return 0;
        for (int s = first_stage; s < 3; s++)
            if (src == dst[s] && tn[s] == 0) return s + 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        if (reset) return 1'b0;
        return src_waits(rs_D, tuse_rs_D) || src_waits(rt_D, tuse_rt_D) ||
               (md_D && (m_busy || md_start_E));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy_end = cyc + 1;
            m_cnt    = '0;
            chk_en   = 1'b1;
        end else begin
            if (exp_stall()) m_cnt = m_cnt + 32'd1;
            if (md_start_E && m_busy) $error("md start issued while MD unit busy");
            if (md_start_E && !m_busy)
                busy_end = cyc + 1 + (md_div_E ? DIV_LAT : MULT_LAT);
        end
        cyc    = cyc + 1;
        m_busy = (cyc < busy_end);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_stall_F",  stall_F,  exp_stall());
            chk("m_stall_D",  stall_D,  exp_stall());
            chk("m_flush_E",  flush_E,  exp_stall());
            chk("m_fwd_rs_D", fwd_rs_D, exp_fwd(rs_D, 0));
            chk("m_fwd_rt_D", fwd_rt_D, exp_fwd(rt_D, 0));
            chk("m_fwd_rs_E", fwd_rs_E, exp_fwd(rs_E, 1));
            chk("m_fwd_rt_E", fwd_rt_E, exp_fwd(rt_E, 1));
            chk("m_fwd_rt_M", fwd_rt_M, (!reset && rt_M != 5'd0 && rt_M == a3_W));
            chk("m_md_busy",  md_busy,  m_busy);
`ifdef HAZARD_STATS_EN
            chk("m_stall_cnt", stall_cnt, m_cnt);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; rt_M = 0;
        a3_E = 0; a3_M = 0; a3_W = 0; tnew_E = 0; tnew_M = 0;
        tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
        md_D = 0; md_start_E = 0; md_div_E = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    task automatic md_run(input logic div, input int exp_busy);
        int nb;
        int ns;
        step(); clr();
        md_start_E = 1'b1; md_div_E = div; md_D = 1'b1;
        probe();
        chk("md_start_stall", stall_F, 1);
        step();
        md_start_E = 1'b0; md_div_E = 1'b0;
        nb = 0; ns = 1;
        for (int i = 0; i < 20; i++) begin
            probe();
            if (!md_busy) break;
            nb++;
            if (stall_F) ns++;
            step();
        end
        chk(div ? "div_busy_cycles" : "mult_busy_cycles", nb, exp_busy);
        chk(div ? "div_stall_cycles" : "mult_stall_cycles", ns, exp_busy + 1);
        chk("md_release", stall_F, 0);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        // conflicting hazards while in reset must be masked
        rs_D = 5'd1; tuse_rs_D = 2'd1; a3_E = 5'd1; tnew_E = 2'd2;
        rt_D = 5'd4; tuse_rt_D = 2'd1; a3_M = 5'd4; tnew_M = 2'd0;
        step();
        probe();
        chk("rst_stall", stall_F, 0);
        chk("rst_fwd_rt_D", fwd_rt_D, 0);
        chk("rst_md_busy", md_busy, 0);
        step(); reset = 1'b0; clr();

        a3_E = 5'd1; tnew_E = 2'd2; rs_D = 5'd1; tuse_rs_D = 2'd1;
        probe();
        chk("lw_stall", stall_F, 1);
        chk("lw_flush", flush_E, 1);
        step(); a3_E = 0; tnew_E = 0; a3_M = 5'd1; tnew_M = 2'd1;
        probe();
        chk("lw_in_m_nostall", stall_D, 0);

        step(); clr();
        a3_E = 5'd5; tnew_E = 2'd1; rs_D = 5'd5; tuse_rs_D = 2'd0;
        probe();
        chk("beq_stall", stall_F, 1);
        step(); a3_E = 0; tnew_E = 0; a3_M = 5'd5; tnew_M = 2'd0;
        probe();
        chk("beq_fwd_m", fwd_rs_D, 2);
        chk("beq_go", stall_F, 0);

        step(); clr();
        a3_E = 5'd31; tnew_E = 2'd0; rs_D = 5'd31; tuse_rs_D = 2'd0;
        probe();
        chk("jr_fwd_e", fwd_rs_D, 1);
        chk("jr_go", stall_F, 0);
        step(); a3_M = 5'd31; tnew_M = 2'd0; a3_W = 5'd31;
        probe();
        chk("jr_e_wins", fwd_rs_D, 1);

        step(); clr();
        rt_D = 5'd9; tuse_rt_D = 2'd1; a3_W = 5'd9; rt_E = 5'd9; rt_M = 5'd9;
        rs_E = 5'd7; a3_M = 5'd7; tnew_M = 2'd0;
        probe();
        chk("fwd_rt_D_w", fwd_rt_D, 3);
        chk("fwd_rs_E_m", fwd_rs_E, 2);
        chk("fwd_rt_E_w", fwd_rt_E, 3);
        chk("fwd_rt_M_w", fwd_rt_M, 1);

        step(); clr();
        rs_E = 5'd6; a3_E = 5'd6; tnew_E = 2'd0;
        probe();
        chk("fwd_rs_E_never_e", fwd_rs_E, 0);
        chk("fwd_rt_M_r0", fwd_rt_M, 0);

        step(); clr();
        rs_D = 5'd0; tuse_rs_D = 2'd0; a3_E = 5'd0; tnew_E = 2'd2;
        probe();
        chk("r0_nostall", stall_F, 0);
        chk("r0_nofwd", fwd_rs_D, 0);

        step(); clr();
        rt_D = 5'd3; tuse_rt_D = 2'd2; rs_D = 5'd3; tuse_rs_D = 2'd3;
        a3_E = 5'd3; tnew_E = 2'd2;
        probe();
        chk("store_tuse_eq_tnew", stall_F, 0);

        md_run(1'b0, MULT_LAT);
        md_run(1'b1, DIV_LAT);

        // reset in the middle of a mult busy period
        step(); clr();
        md_start_E = 1'b1; md_D = 1'b1;
        step(); md_start_E = 1'b0;
        step();
        step(); reset = 1'b1;
        probe();
        chk("busy_at_reset", md_busy, 1);
        chk("reset_masks_md_stall", stall_F, 0);
        step(); reset = 1'b0;
        probe();
        chk("abort_busy", md_busy, 0);
        chk("abort_mflo_go", stall_F, 0);
`ifdef HAZARD_STATS_EN
        chk("abort_stall_cnt", stall_cnt, 0);
`endif

        step(); clr();
        a3_E = 5'd2; tnew_E = 2'd2; rs_D = 5'd2; tuse_rs_D = 2'd0;
        step();
        step(); clr();
        probe();
`ifdef HAZARD_STATS_EN
        chk("stall_cnt_two", stall_cnt, 2);
`endif
        chk("idle_nostall", stall_F, 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
